// File: rtl/opl3_host_master.sv
// OPL3 host-port bus-cycle generator: turns register-write requests into address/data
// write cycles and runs single status-read cycles, with programmable strobe timing.
module opl3_host_master #(
  parameter int unsigned SETUP_CYCLES        = 1,
  parameter int unsigned PULSE_CYCLES        = 4,
  parameter int unsigned HOLD_CYCLES         = 1,
  parameter int unsigned ADDR_WAIT_CYCLES    = 8,
  parameter int unsigned DATA_WAIT_CYCLES    = 8,
  parameter bit          SKIP_REDUNDANT_ADDR = 1'b0,
  parameter int unsigned REG_FILE_DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           ic_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_rd,
  input  logic                           req_bank,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req_addr,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req_data,
  output logic                           rsp_valid,
  output logic [REG_FILE_DATA_WIDTH-1:0] rsp_data,
  output logic                           cs_n,
  output logic                           wr_n,
  output logic                           rd_n,
  output logic [1:0]                     address,
  output logic [REG_FILE_DATA_WIDTH-1:0] bus_dout,
  input  logic [REG_FILE_DATA_WIDTH-1:0] bus_din
);
  localparam int unsigned W     = REG_FILE_DATA_WIDTH;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
  typedef enum logic [1:0] {PH_ADDR, PH_DATA, PH_READ} phase_t;

  function automatic logic [CNT_W-1:0] load_cnt(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bank_q, bank_d;
  logic [W-1:0]     raddr_q, raddr_d, rdata_q, rdata_d;
  logic             last_vld_q, last_vld_d, last_bank_q, last_bank_d;
  logic [W-1:0]     last_addr_q, last_addr_d;
  logic             req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d, bus_dout_q, bus_dout_d;
  logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [1:0]       address_q, address_d;
  logic             addr_match;

  assign addr_match = last_vld_q && (last_bank_q == req_bank) && (last_addr_q == req_addr);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    raddr_d     = raddr_q;
    rdata_d     = rdata_q;
    last_vld_d  = last_vld_q;
    last_bank_d = last_bank_q;
    last_addr_d = last_addr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          bank_d  = req_bank;
          raddr_d = req_addr;
          rdata_d = req_data;
          state_d = S_SETUP;
          cnt_d   = load_cnt(SETUP_CYCLES);
          if (req_rd)                               phase_d = PH_READ;
          else if (SKIP_REDUNDANT_ADDR && addr_match) phase_d = PH_DATA;
          else                                      phase_d = PH_ADDR;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = load_cnt(PULSE_CYCLES);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = load_cnt(HOLD_CYCLES);
          if (phase_q == PH_READ) rsp_data_d = bus_din;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (phase_q == PH_READ) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = (phase_q == PH_ADDR) ? load_cnt(ADDR_WAIT_CYCLES)
                                           : load_cnt(DATA_WAIT_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (phase_q == PH_ADDR) begin
            // The address is only remembered once its write has fully completed.
            last_vld_d  = 1'b1;
            last_bank_d = bank_q;
            last_addr_d = raddr_q;
            phase_d     = PH_DATA;
            state_d     = S_SETUP;
            cnt_d       = load_cnt(SETUP_CYCLES);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are decoded from the next state so every pin comes straight off a flop.
    req_ready_d = (state_d == S_IDLE);
    cs_n_d      = !(state_d == S_SETUP || state_d == S_PULSE || state_d == S_HOLD);
    wr_n_d      = !(state_d == S_PULSE && phase_d != PH_READ);
    rd_n_d      = !(state_d == S_PULSE && phase_d == PH_READ);
    address_d   = address_q;
    bus_dout_d  = bus_dout_q;
    if (state_d == S_SETUP) begin
      unique case (phase_d)
        PH_ADDR: begin address_d = {bank_d, 1'b0}; bus_dout_d = raddr_d; end
        PH_DATA: begin address_d = {bank_d, 1'b1}; bus_dout_d = rdata_d; end
        default: address_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_ADDR;
      cnt_q       <= '0;
      bank_q      <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
      last_vld_q  <= 1'b0;
      last_bank_q <= 1'b0;
      last_addr_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      address_q   <= 2'b00;
      bus_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      raddr_q     <= raddr_d;
      rdata_q     <= rdata_d;
      last_vld_q  <= last_vld_d;
      last_bank_q <= last_bank_d;
      last_addr_q <= last_addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      address_q   <= address_d;
      bus_dout_q  <= bus_dout_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign rd_n      = rd_n_q;
  assign address   = address_q;
  assign bus_dout  = bus_dout_q;

endmodule

// File: tb/tb_opl3_host_master.sv
// Bench for opl3_host_master: one instance without and one with redundant-address skipping,
// each compared cycle by cycle against a timing-window model of the host bus.
module tb_opl3_host_master;
  localparam int S = 1, P = 4, H = 1, AW = 8, DW = 8;
  localparam int SPH = S + P + H;

  logic       clk = 1'b0;
  logic       ic_n;
  logic       req_valid0, req_valid1;
  logic       req_rd, req_bank;
  logic [7:0] req_addr, req_data, bus_din;
  logic       req_ready0, rsp_valid0, cs_n0, wr_n0, rd_n0;
  logic       req_ready1, rsp_valid1, cs_n1, wr_n1, rd_n1;
  logic [1:0] address0, address1;
  logic [7:0] rsp_data0, bus_dout0, rsp_data1, bus_dout1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance
  logic [1:0] exp_addr[2];
  logic [7:0] exp_dout[2];
  logic [7:0] exp_rsp[2];
  bit         last_vld[2];
  logic       last_bank[2];
  logic [7:0] last_addr[2];

  always #5 clk = ~clk;

  opl3_host_master #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .ADDR_WAIT_CYCLES(AW), .DATA_WAIT_CYCLES(DW), .SKIP_REDUNDANT_ADDR(1'b0),
    .REG_FILE_DATA_WIDTH(8)) dut0 (
    .clk(clk), .ic_n(ic_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_rd(req_rd), .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .cs_n(cs_n0), .wr_n(wr_n0), .rd_n(rd_n0),
    .address(address0), .bus_dout(bus_dout0), .bus_din(bus_din));

  opl3_host_master #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .ADDR_WAIT_CYCLES(AW), .DATA_WAIT_CYCLES(DW), .SKIP_REDUNDANT_ADDR(1'b1),
    .REG_FILE_DATA_WIDTH(8)) dut1 (
    .clk(clk), .ic_n(ic_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_rd(req_rd), .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1),
    .address(address1), .bus_dout(bus_dout1), .bus_din(bus_din));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {cs_n, wr_n, rd_n, address, bus_dout, req_ready, rsp_valid, rsp_data}
  function automatic logic [31:0] obs(input int d);
    if (d == 0)
      return {9'b0, cs_n0, wr_n0, rd_n0, address0, bus_dout0, req_ready0, rsp_valid0, rsp_data0};
    return {9'b0, cs_n1, wr_n1, rd_n1, address1, bus_dout1, req_ready1, rsp_valid1, rsp_data1};
  endfunction

  function automatic logic [31:0] rst_vec(input logic rdy);
    return {9'b0, 3'b111, 2'b00, 8'h00, rdy, 1'b0, 8'h00};
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? req_ready0 : req_ready1;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d == 0) req_valid0 = v;
    else        req_valid1 = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = 2'b00; exp_dout[i] = 8'h00; exp_rsp[i] = 8'h00;
      last_vld[i] = 1'b0;  last_bank[i] = 1'b0; last_addr[i] = 8'h00;
    end
  endtask

  // Called at a negedge. Presents one request, then checks every cycle up to the
  // return of req_ready against the strobe windows the timing rules define.
  task automatic do_txn(input int d, input bit rd, input logic bank, input logic [7:0] a,
                        input logic [7:0] v, input logic [7:0] din, input bit hold);
    int   waitc = 0;
    bit   skip;
    int   total, nw, b, ty;
    logic cs, st, ready, rspv;
    while (!rdy(d) && waitc < 200) begin @(negedge clk); waitc++; end
    if (!rdy(d)) begin
      check($sformatf("d%0d ready_timeout", d), 32'd0, 32'd1);
      return;
    end
    req_rd = rd; req_bank = bank; req_addr = a; req_data = v; bus_din = din;
    set_valid(d, 1'b1);
    skip  = (d == 1) && !rd && last_vld[d] && (last_bank[d] == bank) && (last_addr[d] == a);
    total = rd ? SPH : (skip ? SPH + DW : 2 * SPH + AW + DW);
    nw    = (rd || skip) ? 1 : 2;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) begin
        set_valid(d, 1'b0);
        req_rd = 1'($urandom); req_bank = 1'($urandom);
        req_addr = 8'($urandom); req_data = 8'($urandom);
      end
      if (k > S + P) bus_din = 8'($urandom);
      cs = 1'b1; st = 1'b0;
      for (int w = 0; w < nw; w++) begin
        b  = (w == 0) ? 0 : SPH + AW;
        ty = (w == 1) ? 1 : (rd ? 2 : (skip ? 1 : 0));  // 0 addr, 1 data, 2 read
        if (k == b) begin
          if (ty == 0)      begin exp_addr[d] = {bank, 1'b0}; exp_dout[d] = a; end
          else if (ty == 1) begin exp_addr[d] = {bank, 1'b1}; exp_dout[d] = v; end
          else              exp_addr[d] = 2'b00;
        end
        if (k >= b && k < b + SPH)       cs = 1'b0;
        if (k >= b + S && k < b + S + P) st = 1'b1;
      end
      if (rd && k == S + P) exp_rsp[d] = din;
      ready = (k == total);
      rspv  = rd && (k == total);
      check($sformatf("d%0d %s k%0d", d, rd ? "rd" : (skip ? "wr_skip" : "wr"), k), obs(d),
            {9'b0, cs, !(st && !rd), !(st && rd), exp_addr[d], exp_dout[d], ready, rspv, exp_rsp[d]});
    end
    if (!rd) begin
      last_vld[d] = 1'b1; last_bank[d] = bank; last_addr[d] = a;
    end
  endtask

  task automatic rand_txns(input int d, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 8'hA0;
        1:       a = 8'hB0;
        default: a = 8'($urandom);
      endcase
      do_txn(d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), a,
             8'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    ic_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_rd = 1'b0; req_bank = 1'b0; req_addr = 8'h00; req_data = 8'h00; bus_din = 8'h00;
    model_reset();

    // Reset held with clock running
    repeat (3) @(negedge clk);
    check("rst_hold d0", obs(0), rst_vec(1'b0));
    check("rst_hold d1", obs(1), rst_vec(1'b0));
    ic_n = 1'b1;
    #1;
    check("rst_release d0", obs(0), rst_vec(1'b0));
    @(negedge clk);
    check("rst_first_edge d0", obs(0), rst_vec(1'b1));
    check("rst_first_edge d1", obs(1), rst_vec(1'b1));

    // Default write, then status read; rsp_data must persist into the next write
    do_txn(0, 1'b0, 1'b1, 8'h05, 8'h01, 8'h00, 1'b0);
    do_txn(0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hE0, 1'b0);
    do_txn(0, 1'b0, 1'b0, 8'hA0, 8'h33, 8'h00, 1'b0);
    do_txn(0, 1'b0, 1'b0, 8'hA0, 8'h34, 8'h00, 1'b0);
    rand_txns(0, 25);

    // Abort a write mid-PULSE with an asynchronous reset
    req_rd = 1'b0; req_bank = 1'b1; req_addr = 8'h20; req_data = 8'h55;
    req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_pulse wr_n", {31'b0, wr_n0}, 32'd0);
    #2 ic_n = 1'b0;
    #1;
    check("abort_rst d0", obs(0), rst_vec(1'b0));
    check("abort_rst d1", obs(1), rst_vec(1'b0));
    model_reset();
    @(negedge clk);
    ic_n = 1'b1;
    #1;
    check("abort_release d0", obs(0), rst_vec(1'b0));
    @(negedge clk);
    check("abort_first_edge d0", obs(0), rst_vec(1'b1));

    // Skip-enabled instance
    do_txn(1, 1'b0, 1'b0, 8'hA0, 8'h10, 8'h00, 1'b0);
    do_txn(1, 1'b0, 1'b0, 8'hA0, 8'h20, 8'h00, 1'b0);
    do_txn(1, 1'b0, 1'b1, 8'hA0, 8'h30, 8'h00, 1'b0);
    do_txn(1, 1'b0, 1'b0, 8'hB0, 8'h40, 8'h00, 1'b0);
    do_txn(1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0);
    do_txn(1, 1'b0, 1'b0, 8'hB0, 8'h41, 8'h00, 1'b0);

    // Back-to-back with req_valid held high
    do_txn(1, 1'b0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b1);
    do_txn(1, 1'b0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b1);
    do_txn(1, 1'b0, 1'b0, 8'h41, 8'h78, 8'h00, 1'b1);
    req_valid1 = 1'b0;
    rand_txns(1, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
